// File: rtl/bram_wb_pkg.sv
// ============================================================================
// Package : conbus_defs
// Brief   : Shared bus cycle-type codes and bram_wb FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package conbus_defs;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SINGLE = 2'b01,
    BURST  = 2'b10
  } bram_state_t;

endpackage

`default_nettype wire

// File: rtl/bram_wb_ram.sv
// ============================================================================
// Module  : bram_wb_ram
// Brief   : Single-port synchronous 32-bit RAM, byte write enables, read-first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_wb_ram #(
  parameter int adr_width = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [adr_width-1:0] i_adr,
  input  logic [3:0]           i_we,
  input  logic [31:0]          i_din,
  output logic [31:0]          o_dout
);

  localparam int c_depth = 1 << adr_width;

  logic [31:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        r_mem[i_adr][8*i +: 8] <= i_din[8*i +: 8];
      end
    end
  end

  // Read-first: a same-cycle write is seen by the following read only.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dout <= 32'h0000_0000;
    end else begin
      o_dout <= r_mem[i_adr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_wb.sv
// ============================================================================
// Module  : bram_wb
// Brief   : Wishbone slave around a 32-bit block RAM, classic and linear
//           incrementing bursts (one ack per cycle when BRAM_WB_BURST_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_wb
  import conbus_defs::*;
#(
  parameter int adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [2:0]  wb_cti_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  localparam logic [adr_width-1:0] c_one = {{(adr_width-1){1'b0}}, 1'b1};

  bram_state_t          r_state;
  bram_state_t          w_state_next;
  logic                 r_ack;
  logic                 w_ack_next;
  logic                 w_req;
  logic [adr_width-1:0] w_wa;
  logic [adr_width-1:0] w_ram_adr;
  logic [3:0]           w_ram_we;

  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_wa     = wb_adr_i[adr_width+1:2];
  assign wb_ack_o = r_ack & w_req;
  // A beat caught by reset is dropped rather than written.
  assign w_ram_we = (wb_ack_o & wb_we_i & ~sys_rst) ? wb_sel_i : 4'b0000;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ack_next   = 1'b0;
    w_ram_adr    = w_wa;
    case (r_state)
      IDLE: begin
        if (w_req & ~r_ack) begin
          w_ack_next = 1'b1;
`ifdef BRAM_WB_BURST_EN
          w_state_next = (wb_cti_i == CTI_INCR) ? BURST : SINGLE;
`else
          w_state_next = SINGLE;
`endif
        end
      end
      SINGLE: begin
        w_state_next = IDLE;
      end
`ifdef BRAM_WB_BURST_EN
      BURST: begin
        if (w_req && (wb_cti_i != CTI_END)) begin
          w_ack_next = 1'b1;
          // Prefetch the next word so its data lines up with the next ack.
          if (!wb_we_i) begin
            w_ram_adr = w_wa + c_one;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  bram_wb_ram #(
    .adr_width (adr_width)
  ) u_ram (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .i_adr  (w_ram_adr),
    .i_we   (w_ram_we),
    .i_din  (wb_dat_i),
    .o_dout (wb_dat_o)
  );

  logic w_unused_inputs;
`ifdef BRAM_WB_BURST_EN
  assign w_unused_inputs = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};
`else
  assign w_unused_inputs = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0], wb_cti_i};
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_wb.sv
// ============================================================================
// Module  : tb_bram_wb
// Brief   : Randomized self-checking bench for bram_wb against a word-array model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_wb;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_WB_BURST_EN
  localparam bit BURST_MODE = 1'b1;
`else
  localparam bit BURST_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [2:0]  cti;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_model [DEPTH];
  bit          known     [DEPTH];

  always #5 clk = ~clk;

  bram_wb #(.adr_width(AW)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_w),
    .wb_dat_o (dat_r),
    .wb_cti_i (cti),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_ack_o (ack)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; sel = 4'h0;
  endtask

  // Unused address bits are randomized to prove they are ignored.
  task automatic drive_beat(input int w, input bit we_b, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] c);
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = w[AW-1:0];
    adr = a; cyc = 1'b1; stb = 1'b1; we = we_b; dat_w = d; sel = s; cti = c;
  endtask

  // Cycles between presentation and ack, sampled on the falling edge.
  task automatic wait_ack(output int waited);
    waited = 0;
    @(negedge clk);
    while (!ack && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!ack) check_value("ack_timeout", {31'b0, ack}, 32'd1);
  endtask

  task automatic beat_result(input int w, input bit we_b, input logic [31:0] d,
                             input logic [3:0] s, input string tag);
    if (ack) begin
      if (we_b) begin
        mem_model[w] = merge(known[w] ? mem_model[w] : 32'h0, d, s);
        known[w] = (s == 4'hf) ? 1'b1 : known[w];
      end else if (known[w]) begin
        check_value(tag, dat_r, mem_model[w]);
      end
    end
  endtask

  task automatic classic(input int w, input bit we_b, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] c, input string tag, output logic [31:0] rd);
    int waited;
    @(posedge clk); #1;
    drive_beat(w, we_b, d, s, c);
    wait_ack(waited);
    check_value({tag, "_lat"}, waited, 32'd1);
    rd = dat_r;
    beat_result(w, we_b, d, s, tag);
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic burst(input int start_w, input bit we_b, input int n, input int drop_after,
                       input string tag);
    int w, waited;
    logic [31:0] d;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      w = (start_w + k) % DEPTH;
      d = $urandom;
      drive_beat(w, we_b, d, 4'hf, (k == n-1 && drop_after < 0) ? 3'b111 : 3'b010);
      wait_ack(waited);
      check_value({tag, "_lat"}, waited, (k == 0 || !BURST_MODE) ? 32'd1 : 32'd0);
      beat_result(w, we_b, d, 4'hf, tag);
      if (!ack) begin
        idle_bus();
        return;
      end
      @(posedge clk); #1;
      if (drop_after == k + 1) begin
        stb = 1'b0;
        @(negedge clk);
        check_value({tag, "_drop_ack"}, {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        idle_bus();
        return;
      end
    end
    // Hold a read strobe after the final beat: it must not be acked yet.
    we = 1'b0; cti = 3'b000;
    @(negedge clk);
    check_value({tag, "_end_ack"}, {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    idle_bus();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] d1, d2;
    int waited, w, n;
    logic [2:0] c;

    for (int i = 0; i < DEPTH; i++) begin
      known[i] = 1'b0;
      mem_model[i] = 32'h0;
    end
    dat_w = 32'h0; adr = 32'h0;
    idle_bus();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check_value("rst_ack", {31'b0, ack}, 32'd0);
    check_value("rst_dat", dat_r, 32'h0);
    @(posedge clk); #1;
    idle_bus();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (i < 32 || (i >= 60 && i <= 70) || (i >= 126 && i <= 150) ||
          (i >= 190 && i <= 200) || i >= DEPTH - 8)
        classic(i, 1'b1, $urandom, 4'hf, 3'b000, "prefill", rd);
    end

    classic(4, 1'b1, 32'hDEADBEEF, 4'hf, 3'b000, "t1_wr", rd);
    classic(4, 1'b0, 32'h0, 4'hf, 3'b000, "t1_rd", rd);
    check_value("t1_val", rd, 32'hDEADBEEF);

    classic(8, 1'b1, 32'h11223344, 4'hf, 3'b000, "t2_wr", rd);
    classic(8, 1'b1, 32'h0000AA00, 4'b0010, 3'b000, "t2_wr_lane", rd);
    classic(8, 1'b0, 32'h0, 4'hf, 3'b000, "t2_rd", rd);
    check_value("t2_val", rd, 32'h1122AA44);

    for (int k = 0; k < 4; k++)
      classic(64 + k, 1'b1, 32'hA0A0_A0A0 + k, 4'hf, 3'b000, "t3_pre", rd);
    burst(64, 1'b0, 4, -1, "t3_burst_rd");

    burst(128, 1'b1, 4, -1, "t4_burst_wr");
    for (int k = 0; k < 5; k++)
      classic(128 + k, 1'b0, 32'h0, 4'hf, 3'b000, "t4_rd", rd);

    burst(192, 1'b0, 6, 2, "t5_drop");
    classic(192, 1'b0, 32'h0, 4'hf, 3'b000, "t5_after", rd);
    burst(DEPTH - 1, 1'b0, 2, -1, "t5_wrap");

    d1 = 32'hC0FFEE01;
    d2 = 32'hBADC0DE2;
    @(posedge clk); #1;
    drive_beat(140, 1'b1, d1, 4'hf, 3'b010);
    wait_ack(waited);
    check_value("t6_beat1_lat", waited, 32'd1);
    beat_result(140, 1'b1, d1, 4'hf, "t6_beat1");
    @(posedge clk); #1;
    drive_beat(141, 1'b1, d2, 4'hf, 3'b010);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_value("t6_rst_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    idle_bus();
    classic(141, 1'b0, 32'h0, 4'hf, 3'b000, "t6_beat2_word", rd);
    classic(140, 1'b0, 32'h0, 4'hf, 3'b000, "t6_beat1_word", rd);
    check_value("t6_beat1_val", rd, d1);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          w = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : $urandom_range(DEPTH - 8, DEPTH - 1);
          c = 3'($urandom_range(0, 7));
          if (c == 3'b010) c = 3'b001;
          if ($urandom_range(0, 1) == 0)
            classic(w, 1'b1, $urandom, 4'($urandom_range(1, 15)), c, "rnd_wr", rd);
          else
            classic(w, 1'b0, 32'h0, 4'hf, c, "rnd_rd", rd);
        end
        default: begin
          w = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 24) : $urandom_range(DEPTH - 5, DEPTH - 1);
          n = $urandom_range(1, 5);
          burst(w, 1'($urandom_range(0, 1)), n, -1, "rnd_burst");
        end
      endcase
    end
    for (int i = 0; i < 32; i++)
      classic(i, 1'b0, 32'h0, 4'hf, 3'b000, "final_rd", rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
